ysyx_2022040010_mem_arb: RTL and testbench

Single-port memory arbiter sharing one memory bus between the instruction-fetch requester (IF stage fetch port) and the load/store requester (MEM stage). Serialises at most one outstanding transaction, drives a valid/ready request channel plus a response-valid channel toward memory, and raises a stall request to the pipeline controller while any access is pending. Sits between the IF/MEM stages and the memory bus.

---
 rtl/ysyx_2022040010_mem_arb_pkg.sv | 34 +++
 rtl/ysyx_2022040010_mem_arb_if.sv | 61 ++++++
 rtl/ysyx_2022040010_arb_pick.sv | 66 ++++++
 rtl/ysyx_2022040010_mem_arb.sv | 169 ++++++++++++++++
 tb/tb_ysyx_2022040010_mem_arb.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_2022040010_mem_arb_pkg.sv
// ysyx_2022040010_mem_arb_pkg
//   Shared types and constants for the single-port memory arbiter:
//   FSM state encoding, bus-owner ids, bus widths and the instruction
//   slice helper.
//   Optional feature macro: YSYX_2022040010_ARB_RR_EN (round-robin pick).
package ysyx_2022040010_mem_arb_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_INST_W = 32;
  localparam int ARB_MASK_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_IF = 1'b0,
    ARB_LS = 1'b1
  } arb_owner_e;

  // Pick the 32-bit instruction out of a 64-bit memory word; address bit 2
  // selects the upper half.
  function automatic logic [ARB_INST_W-1:0] arb_inst_slice(
    input logic [ARB_DATA_W-1:0] data,
    input logic                  hi
  );
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_2022040010_mem_arb_if.sv
// ysyx_2022040010_mem_arb_if
//   Bundle of every handshake/payload signal around the arbiter:
//   IF fetch port (if_*), load/store port (ls_*), memory bus (mem_*) and
//   the pipeline stall request.
//   modport master : the arbiter (it masters the memory bus and answers
//                    both requesters).
//   modport slave  : the environment (IF/MEM stages and the memory).
interface ysyx_2022040010_mem_arb_if
  import ysyx_2022040010_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) ();

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [ARB_INST_W-1:0] if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [ARB_MASK_W-1:0] ls_wmask;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ARB_MASK_W-1:0] mem_wmask;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  stallreq;

  modport master (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_wmask, ls_addr, ls_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_valid, mem_we, mem_wmask, mem_addr, mem_wdata,
    output stallreq
  );

  modport slave (
    output if_req, if_addr,
    output ls_req, ls_we, ls_wmask, ls_addr, ls_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_valid, mem_we, mem_wmask, mem_addr, mem_wdata,
    input  stallreq
  );

endinterface

// File: rtl/ysyx_2022040010_arb_pick.sv
// ysyx_2022040010_arb_pick
//   Two-requester grant pick. Grants are combinational and only issued
//   while en_i is high (arbiter idle and out of reset).
//   Default: fixed priority, load/store over fetch, no state.
//   With YSYX_2022040010_ARB_RR_EN: on a collision the requester that was
//   not granted most recently wins; the pointer updates on every grant and
//   resets to "LS granted last" so that fetch is preferred after reset.
//   Ports: clk/rst (round-robin build only), en_i, if_req_i, ls_req_i,
//          if_gnt_o, ls_gnt_o.
module ysyx_2022040010_arb_pick
  import ysyx_2022040010_mem_arb_pkg::*;
(
`ifdef YSYX_2022040010_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en_i,
  input  logic if_req_i,
  input  logic ls_req_i,
  output logic if_gnt_o,
  output logic ls_gnt_o
);

`ifdef YSYX_2022040010_ARB_RR_EN
  arb_owner_e last_q;

  // Remember which requester was granted most recently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= ARB_LS;
    end else if (if_gnt_o) begin
      last_q <= ARB_IF;
    end else if (ls_gnt_o) begin
      last_q <= ARB_LS;
    end else begin
      last_q <= last_q;
    end
  end
`endif

  // Grant decision for the current cycle.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (en_i) begin
      if (if_req_i && ls_req_i) begin
`ifdef YSYX_2022040010_ARB_RR_EN
        if (last_q == ARB_LS) begin
          if_gnt_o = 1'b1;
        end else begin
          ls_gnt_o = 1'b1;
        end
`else
        ls_gnt_o = 1'b1;
`endif
      end else begin
        if_gnt_o = if_req_i;
        ls_gnt_o = ls_req_i;
      end
    end else begin
      if_gnt_o = 1'b0;
      ls_gnt_o = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_2022040010_mem_arb.sv
// ysyx_2022040010_mem_arb
//   Shares one memory bus between the IF fetch port and the MEM-stage
//   load/store port, one transaction at a time:
//     IDLE -> (grant) REQ -> (mem_ready) WAIT -> (mem_rvalid) DONE -> IDLE
//   The winner's gnt pulses combinationally in IDLE while its payload is
//   latched; mem_valid and the payload come from those latches in REQ;
//   the response is latched in WAIT and handed back with a one-cycle
//   rvalid in DONE. stallreq holds the pipeline while an access is pending
//   and drops in DONE so the pipeline advances together with the data.
//   Optional feature macro: YSYX_2022040010_ARB_RR_EN (round-robin pick).
//   Ports: clk, rst (synchronous, active low), bus (master modport of
//          ysyx_2022040010_mem_arb_if: if_*, ls_*, mem_*, stallreq).
module ysyx_2022040010_mem_arb
  import ysyx_2022040010_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_2022040010_mem_arb_if.master bus
);

  arb_state_e            state_q;
  arb_state_e            state_d;
  arb_owner_e            owner_q;
  logic                  mem_valid_q;
  logic                  we_q;
  logic [ARB_MASK_W-1:0] wmask_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  if_rvalid_q;
  logic                  ls_rvalid_q;
  logic [ARB_INST_W-1:0] if_rdata_q;
  logic [DATA_W-1:0]     ls_rdata_q;

  logic                  pick_en_s;
  logic                  pick_if_s;
  logic                  pick_ls_s;

  // Grants are suppressed during reset so a held request is not accepted
  // in the reset cycle.
  assign pick_en_s = rst && (state_q == ARB_IDLE);

  ysyx_2022040010_arb_pick u_pick (
`ifdef YSYX_2022040010_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .en_i     (pick_en_s),
    .if_req_i (bus.if_req),
    .ls_req_i (bus.ls_req),
    .if_gnt_o (pick_if_s),
    .ls_gnt_o (pick_ls_s)
  );

  // Next-state logic of the transaction FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_if_s || pick_ls_s) begin
          state_d = ARB_REQ;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        if (bus.mem_ready) begin
          state_d = ARB_WAIT;
        end else begin
          state_d = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = ARB_DONE;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // FSM state, request latches and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_IF;
      mem_valid_q <= 1'b0;
      we_q        <= 1'b0;
      wmask_q     <= {ARB_MASK_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= {ARB_INST_W{1'b0}};
      ls_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      // rvalid is a single-cycle pulse, raised only on WAIT -> DONE.
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_ls_s) begin
            owner_q     <= ARB_LS;
            we_q        <= bus.ls_we;
            wmask_q     <= bus.ls_wmask;
            addr_q      <= bus.ls_addr;
            wdata_q     <= bus.ls_wdata;
            mem_valid_q <= 1'b1;
          end else if (pick_if_s) begin
            // Fetches are always reads with an empty payload.
            owner_q     <= ARB_IF;
            we_q        <= 1'b0;
            wmask_q     <= {ARB_MASK_W{1'b0}};
            addr_q      <= bus.if_addr;
            wdata_q     <= {DATA_W{1'b0}};
            mem_valid_q <= 1'b1;
          end else begin
            mem_valid_q <= 1'b0;
          end
        end
        ARB_REQ: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
          end
        end
        ARB_WAIT: begin
          if (bus.mem_rvalid) begin
            if (owner_q == ARB_LS) begin
              ls_rvalid_q <= 1'b1;
              ls_rdata_q  <= bus.mem_rdata;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= arb_inst_slice(bus.mem_rdata, addr_q[2]);
            end
          end
        end
        ARB_DONE: begin
          mem_valid_q <= 1'b0;
        end
        default: begin
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = pick_if_s;
  assign bus.ls_gnt    = pick_ls_s;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wmask = wmask_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Stall while busy, or while a request waits in IDLE; released in DONE.
  assign bus.stallreq = rst && ((state_q == ARB_REQ) || (state_q == ARB_WAIT) ||
                                ((state_q == ARB_IDLE) && (bus.if_req || bus.ls_req)));

endmodule

// File: tb/tb_ysyx_2022040010_mem_arb.sv
// Testbench for ysyx_2022040010_mem_arb. A timeline model (grant, accept
// and response cycle numbers of the current transaction) predicts every
// output each cycle; directed sequences add hand-computed expectations.
module tb_ysyx_2022040010_mem_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_2022040010_mem_arb_if bus ();

  ysyx_2022040010_mem_arb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_own_ls;
  int          m_tg, m_tacc, m_trsp;
  logic [63:0] m_addr, m_wdata;
  logic        m_we;
  logic [7:0]  m_mask;
  logic [31:0] m_if_rd = 32'h0;
  logic [63:0] m_ls_rd = 64'h0;
  bit          m_last_ls = 1'b1;
  int          mc = 0;

  always @(negedge clk) begin : model_cmp
    bit e_if_g, e_ls_g, e_mv, e_if_rv, e_ls_rv, e_st, in_req, in_done;
    e_if_g = 1'b0; e_ls_g = 1'b0; e_mv = 1'b0; e_if_rv = 1'b0; e_ls_rv = 1'b0;
    in_req = 1'b0; in_done = 1'b0;
    if (m_busy) begin
      in_req  = (mc > m_tg) && (m_tacc < 0);
      in_done = (m_trsp >= 0) && (mc == m_trsp + 1);
      e_mv    = in_req;
      e_if_rv = in_done && !m_own_ls;
      e_ls_rv = in_done && m_own_ls;
      e_st    = rst && !in_done;
    end else begin
      if (rst) begin
        if (bus.if_req && bus.ls_req) begin
`ifdef YSYX_2022040010_ARB_RR_EN
          if (m_last_ls) e_if_g = 1'b1; else e_ls_g = 1'b1;
`else
          e_ls_g = 1'b1;
`endif
        end else begin
          e_if_g = bus.if_req;
          e_ls_g = bus.ls_req;
        end
      end
      e_st = rst && (bus.if_req || bus.ls_req);
    end
    if (chk_en) begin
      chk("m_if_gnt",    64'(bus.if_gnt),    64'(e_if_g));
      chk("m_ls_gnt",    64'(bus.ls_gnt),    64'(e_ls_g));
      chk("m_mem_valid", 64'(bus.mem_valid), 64'(e_mv));
      chk("m_if_rvalid", 64'(bus.if_rvalid), 64'(e_if_rv));
      chk("m_ls_rvalid", 64'(bus.ls_rvalid), 64'(e_ls_rv));
      chk("m_stallreq",  64'(bus.stallreq),  64'(e_st));
      chk("m_if_rdata",  64'(bus.if_rdata),  64'(m_if_rd));
      chk("m_ls_rdata",  bus.ls_rdata,       m_ls_rd);
      if (e_mv) begin
        chk("m_mem_addr",  bus.mem_addr,        m_addr);
        chk("m_mem_we",    64'(bus.mem_we),     64'(m_we));
        chk("m_mem_wmask", 64'(bus.mem_wmask),  64'(m_mask));
        chk("m_mem_wdata", bus.mem_wdata,       m_wdata);
      end
    end
    // Advance the model across the coming clock edge.
    if (!rst) begin
      m_busy = 1'b0; m_if_rd = 32'h0; m_ls_rd = 64'h0; m_last_ls = 1'b1;
    end else if (m_busy) begin
      if (in_done) begin
        m_busy = 1'b0;
      end else if (in_req) begin
        if (bus.mem_ready) m_tacc = mc;
      end else if (m_trsp < 0 && bus.mem_rvalid) begin
        m_trsp = mc;
        if (m_own_ls) m_ls_rd = bus.mem_rdata;
        else m_if_rd = m_addr[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      end
    end else if (e_ls_g || e_if_g) begin
      m_busy = 1'b1; m_tg = mc; m_tacc = -1; m_trsp = -1; m_own_ls = e_ls_g;
      m_last_ls = e_ls_g;
      m_addr  = e_ls_g ? bus.ls_addr : bus.if_addr;
      m_we    = e_ls_g ? bus.ls_we : 1'b0;
      m_mask  = e_ls_g ? bus.ls_wmask : 8'h00;
      m_wdata = e_ls_g ? bus.ls_wdata : 64'h0;
    end
    mc++;
  end

  // ---------------- stimulus helpers ----------------
  bit          resp_en;
  int          rdy_dly, rsp_dly, ph, cnt;
  logic [63:0] rsp_data;
  int          n_if_g = 0, n_ls_g = 0;
  bit          gnt_log[$];

  // One clock: sample grants at negedge, then drive the next cycle's inputs
  // (requesters drop on grant, memory answers with the configured delays).
  task tick();
    bit s_if, s_ls;
    @(negedge clk);
    s_if = bus.if_gnt; s_ls = bus.ls_gnt;
    if (s_if) begin n_if_g++; gnt_log.push_back(1'b0); end
    if (s_ls) begin n_ls_g++; gnt_log.push_back(1'b1); end
    @(posedge clk);
    #1;
    if (s_if) bus.if_req = 1'b0;
    if (s_ls) bus.ls_req = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (resp_en) begin
      if (s_if || s_ls) begin ph = 1; cnt = rdy_dly; end
      if (ph == 1) begin
        if (cnt == 0) begin bus.mem_ready = 1'b1; ph = 2; cnt = rsp_dly; end
        else cnt--;
      end else if (ph == 2) begin
        if (cnt == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rsp_data; ph = 0; end
        else cnt--;
      end
    end
  endtask

  task wait_idle(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!m_busy && !bus.if_req && !bus.ls_req) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task set_ls(input logic we, input logic [7:0] mask, input logic [63:0] addr,
              input logic [63:0] wdata);
    bus.ls_we = we; bus.ls_wmask = mask; bus.ls_addr = addr; bus.ls_wdata = wdata;
  endtask

  int base_if, base_ls;
  bit exp_ls;

  initial begin
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 64'h8000_0004;
    bus.ls_req = 1'b0; set_ls(1'b0, 8'h00, 64'h0, 64'h0);
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
    resp_en = 1'b1; rdy_dly = 0; rsp_dly = 0; ph = 0; cnt = 0;
    rsp_data = 64'h1111_2222_3333_4444;

    // Reset with a fetch request held.
    tick();
    chk_en = 1'b1;
    #1;
    chk("rst_if_gnt",    64'(bus.if_gnt),    64'd0);
    chk("rst_stallreq",  64'(bus.stallreq),  64'd0);
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_if_rdata",  64'(bus.if_rdata),  64'd0);
    tick();
    rst = 1'b1;
    #1;
    // IF read, minimum latency, upper half.
    chk("rd_c0_if_gnt", 64'(bus.if_gnt),   64'd1);
    chk("rd_c0_stall",  64'(bus.stallreq), 64'd1);
    tick(); #1;
    chk("rd_c1_mem_valid", 64'(bus.mem_valid), 64'd1);
    chk("rd_c1_mem_addr",  bus.mem_addr,       64'h8000_0004);
    chk("rd_c1_stall",     64'(bus.stallreq),  64'd1);
    tick(); #1;
    chk("rd_c2_stall",     64'(bus.stallreq),  64'd1);
    chk("rd_c2_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    tick(); #1;
    chk("rd_c3_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    chk("rd_c3_if_rdata",  64'(bus.if_rdata),  64'h1111_2222);
    chk("rd_c3_stall",     64'(bus.stallreq),  64'd0);
    tick(); #1;
    chk("rd_c4_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("rd_c4_if_rdata",  64'(bus.if_rdata),  64'h1111_2222);

    // IF read, lower half.
    bus.if_addr = 64'h8000_0008; bus.if_req = 1'b1;
    wait_idle(20);
    chk("rd_lo_if_rdata", 64'(bus.if_rdata), 64'h3333_4444);

    // Store with three ready-wait cycles and one response-wait cycle.
    rdy_dly = 3; rsp_dly = 1; rsp_data = 64'h0;
    set_ls(1'b1, 8'h0F, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D);
    bus.ls_req = 1'b1;
    #1;
    chk("st_c0_ls_gnt", 64'(bus.ls_gnt), 64'd1);
    chk("st_c0_if_gnt", 64'(bus.if_gnt), 64'd0);
    tick(); tick(); tick(); #1;
    chk("st_c3_mem_valid", 64'(bus.mem_valid), 64'd1);
    chk("st_c3_mem_we",    64'(bus.mem_we),    64'd1);
    chk("st_c3_mem_wmask", 64'(bus.mem_wmask), 64'h0F);
    chk("st_c3_mem_wdata", bus.mem_wdata,      64'hDEAD_BEEF_CAFE_F00D);
    tick(); tick(); tick(); #1;
    chk("st_c6_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    chk("st_c6_stall",     64'(bus.stallreq),  64'd1);
    tick(); #1;
    chk("st_c7_ls_rvalid", 64'(bus.ls_rvalid), 64'd1);
    chk("st_c7_stall",     64'(bus.stallreq),  64'd0);
    tick(); #1;
    chk("st_c8_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);

    // Load with waits.
    rdy_dly = 1; rsp_dly = 2; rsp_data = 64'hA5A5_5A5A_0123_4567;
    set_ls(1'b0, 8'h00, 64'h8000_2000, 64'h0);
    bus.ls_req = 1'b1;
    wait_idle(30);
    chk("ld_ls_rdata", bus.ls_rdata, 64'hA5A5_5A5A_0123_4567);

    // Repeated collisions; the loser drops after the winner's grant.
    rdy_dly = 0; rsp_dly = 0; rsp_data = 64'h0BAD_F00D_1234_5678;
    bus.if_addr = 64'h8000_0010;
    for (int r = 0; r < 3; r++) begin
      bus.if_req = 1'b1; bus.ls_req = 1'b1;
      #1;
`ifdef YSYX_2022040010_ARB_RR_EN
      exp_ls = (r % 2) == 1;
`else
      exp_ls = 1'b1;
`endif
      chk("coll_ls_gnt", 64'(bus.ls_gnt), 64'(exp_ls));
      chk("coll_if_gnt", 64'(bus.if_gnt), 64'(!exp_ls));
      tick();
      bus.if_req = 1'b0; bus.ls_req = 1'b0;
      wait_idle(20);
    end

    // Collision with the loser held: both served, one after the other.
    base_if = n_if_g; base_ls = n_ls_g;
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    wait_idle(40);
    chk("held_if_count", 64'(n_if_g - base_if), 64'd1);
    chk("held_ls_count", 64'(n_ls_g - base_ls), 64'd1);
`ifndef YSYX_2022040010_ARB_RR_EN
    chk("held_first_ls", 64'(gnt_log[gnt_log.size()-2]), 64'd1);
`endif

    // Fetch request raised and dropped while LS owns the bus.
    rdy_dly = 1; rsp_dly = 1;
    base_if = n_if_g;
    bus.ls_req = 1'b1;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 64'h8000_0020;
    tick(); tick();
    bus.if_req = 1'b0;
    wait_idle(20);
    chk("drop_no_if_gnt", 64'(n_if_g - base_if), 64'd0);

    // Reset while waiting for the response; a late response is ignored.
    resp_en = 1'b0; ph = 0;
    bus.ls_req = 1'b1;
    #1;
    chk("rw_c0_ls_gnt", 64'(bus.ls_gnt), 64'd1);
    tick();
    bus.mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rw_rst_stall", 64'(bus.stallreq), 64'd0);
    tick();
    rst = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("rw_post_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rw_post_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    chk("rw_post_stall",     64'(bus.stallreq),  64'd0);
    tick(); #1;
    chk("rw_late_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
    chk("rw_late_ls_rdata",  bus.ls_rdata,       64'h0);
    chk("rw_late_if_rdata",  64'(bus.if_rdata),  64'h0);
    resp_en = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
